// File: rtl/pal_pkg.sv
// Shared types and helpers for the PAL OR plane: mode bit positions, FSM states,
// and the power-on one-hot mask mapping output i to product term (i mod NUM_TERMS).
package pal_pkg;

   localparam int MODE_REG = 0;
   localparam int MODE_INV = 1;

   // Widest OR mask the default-mask helper can describe; callers cast down to NUM_TERMS.
   localparam int PAL_MAX_TERMS = 64;

   typedef logic [1:0] pal_mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } pal_state_e;

   function automatic logic [PAL_MAX_TERMS-1:0] defaultMask(input int idx, input int numTerms);
      return PAL_MAX_TERMS'(1) << (idx % numTerms);
   endfunction

endpackage

// File: rtl/pal_macrocell.sv
// One PAL output: OR of masked product terms, optional inversion, and a
// combinational/registered output select.
module pal_macrocell
   import pal_pkg::*;
#(
   parameter int NUM_TERMS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hold_i,
   input  logic [NUM_TERMS-1:0] terms_i,
   input  logic [NUM_TERMS-1:0] mask_i,
   input  pal_mode_t            mode_i,
   output logic                 y_o
);

   logic orBit;
   logic polBit;
   logic q_q;

   assign orBit  = |(terms_i & mask_i);
   assign polBit = orBit ^ mode_i[MODE_INV];

   // The flop tracks polBit in both modes so switching to registered shows a current value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else if (!hold_i) begin
         q_q <= polBit;
      end
   end

   assign y_o = mode_i[MODE_REG] ? q_q : polBit;

endmodule

// File: rtl/pal_or_plane_cfg.sv
// Programmable PAL OR plane: shadow/active configuration banks with an atomic
// commit, driving NUM_OUTPUTS macrocells.
module pal_or_plane_cfg
   import pal_pkg::*;
#(
   parameter int NUM_TERMS   = 8,
   parameter int NUM_OUTPUTS = 4,
   parameter int ADDR_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_TERMS-1:0]   terms,
   input  logic                   hold,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [ADDR_W-1:0]      cfg_addr,
   input  logic [NUM_TERMS-1:0]   cfg_mask,
   input  logic [1:0]             cfg_mode,
   input  logic                   cfg_commit,
   output logic                   cfg_pending,
   output logic                   cfg_err,
   output logic [NUM_OUTPUTS-1:0] y
);

   localparam logic [ADDR_W:0] NUM_OUT_W = (ADDR_W+1)'(NUM_OUTPUTS);

   pal_state_e state_q, state_d;
   logic       pending_q, pending_d;
   logic       err_q, err_d;

   logic [NUM_TERMS-1:0] shMask_q  [NUM_OUTPUTS];
   logic [NUM_TERMS-1:0] shMask_d  [NUM_OUTPUTS];
   pal_mode_t            shMode_q  [NUM_OUTPUTS];
   pal_mode_t            shMode_d  [NUM_OUTPUTS];
   logic [NUM_TERMS-1:0] actMask_q [NUM_OUTPUTS];
   logic [NUM_TERMS-1:0] actMask_d [NUM_OUTPUTS];
   pal_mode_t            actMode_q [NUM_OUTPUTS];
   pal_mode_t            actMode_d [NUM_OUTPUTS];

   // A write and a commit in the same IDLE cycle both take effect: the shadow
   // updates at that edge and COMMIT copies it one edge later.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      err_d     = 1'b0;
      shMask_d  = shMask_q;
      shMode_d  = shMode_q;
      actMask_d = actMask_q;
      actMode_d = actMode_q;
      cfg_ready = (state_q == IDLE);
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               if ({1'b0, cfg_addr} < NUM_OUT_W) begin
                  for (int i = 0; i < NUM_OUTPUTS; i++) begin
                     if (cfg_addr == ADDR_W'(i)) begin
                        shMask_d[i] = cfg_mask;
                        shMode_d[i] = cfg_mode;
                     end
                  end
                  pending_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            if (cfg_commit) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            actMask_d = shMask_q;
            actMode_d = shMode_q;
            pending_d = 1'b0;
            state_d   = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            shMask_q[i]  <= NUM_TERMS'(defaultMask(i, NUM_TERMS));
            shMode_q[i]  <= '0;
            actMask_q[i] <= NUM_TERMS'(defaultMask(i, NUM_TERMS));
            actMode_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         shMask_q  <= shMask_d;
         shMode_q  <= shMode_d;
         actMask_q <= actMask_d;
         actMode_q <= actMode_d;
      end
   end

   assign cfg_pending = pending_q;
   assign cfg_err     = err_q;

   for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cell
      pal_macrocell #(
         .NUM_TERMS (NUM_TERMS)
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .hold_i  (hold),
         .terms_i (terms),
         .mask_i  (actMask_q[g]),
         .mode_i  (actMode_q[g]),
         .y_o     (y[g])
      );
   end

endmodule
